// File: rtl/cycle_span_pkg.sv
// Shared definitions for the cycle-span capture block: FSM encoding,
// default sizing and the modular span helper.
package cycle_span_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 8;

   // Widest counter the span helper supports; callers truncate the result
   // to their own width, which keeps the subtraction modulo 2^WIDTH.
   localparam int SPAN_W = 64;

   // Elapsed cycles between two counter samples, wrapping modulo 2^SPAN_W.
   function automatic logic [SPAN_W-1:0] span(input logic [SPAN_W-1:0] cnt,
                                              input logic [SPAN_W-1:0] t0);
      return cnt - t0;
   endfunction

endpackage

// File: rtl/cycle_span_capture_span_fifo.sv
// Single-clock measurement FIFO with a registered head entry so the
// consumer sees data straight from flops. Full/empty come from the level
// counter; read/write pointers wrap naturally modulo DEPTH.
module span_fifo
   import cycle_span_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_accept,
   input  logic             pop_ready,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [AW:0]      level
);

   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    rd_next;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             empty;
   logic             full;
   logic             pop;

   assign empty       = (level_q == '0);
   assign full        = (level_q == LVL_FULL);
   assign pop         = !empty && pop_ready;
   assign push_accept = push && (!full || pop);
   assign rd_next     = rd_ptr_q + PTR_ONE;

   assign head_valid  = !empty;
   assign head_data   = head_q;
   assign level       = level_q;

   // Next pointers, occupancy and head entry from this cycle's push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;

      if (push_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_next;
      end

      case ({push_accept, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      // The entry behind the head is either already stored, or is the one
      // being written right now when only a single entry was queued.
      if (pop) begin
         if (level_q > LVL_ONE) begin
            head_d = mem_q[rd_next];
         end else if (push_accept) begin
            head_d = push_data;
         end
      end else if (empty && push_accept) begin
         head_d = push_data;
      end
   end

   // Storage array; contents are meaningless until counted in by level.
   always_ff @(posedge clk) begin
      if (push_accept) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/cycle_span_capture.sv
// Turns start/stop pulses into elapsed-cycle measurements taken from the
// free-running counter and queues them for the host. A start+stop pair
// while running acts as a lap: the span is recorded and timing restarts.
module cycle_span_capture
   import cycle_span_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             start,
   input  logic             stop,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             busy,
   output logic [AW:0]      level,
   output logic             overflow,
   input  logic             clr_ovf
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] t0_q, t0_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] elapsed;
   logic             push_req;
   logic             push_accept;

   // Truncating the wide modular difference gives the WIDTH-bit wrap result.
   assign elapsed  = WIDTH'(span(SPAN_W'(cnt_in), SPAN_W'(t0_q)));

   assign busy     = busy_q;
   assign overflow = ovf_q;

   // Measurement FSM: decide next state, new t0 and whether to record a span.
   always_comb begin
      state_d  = state_q;
      t0_d     = t0_q;
      push_req = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               t0_d    = cnt_in;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               push_req = 1'b1;
               if (start) begin
                  t0_d = cnt_in;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   // Sticky overflow: a dropped measurement beats a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (push_req && !push_accept) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // FSM, start timestamp, busy and overflow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         t0_q    <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t0_q    <= t0_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   span_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push_req),
      .push_data   (elapsed),
      .push_accept (push_accept),
      .pop_ready   (m_ready),
      .head_valid  (m_valid),
      .head_data   (m_data),
      .level       (level)
   );

endmodule

// File: tb/tb_cycle_span_capture.sv
// Scoreboard bench for cycle_span_capture: expected spans are queued as
// stop events are driven and compared as the DUT hands them out.
module tb_cycle_span_capture;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] cnt_in;
   logic             start;
   logic             stop;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             busy;
   logic [AW:0]      level;
   logic             overflow;
   logic             clr_ovf;

   int compared   = 0;
   int mismatched = 0;
   int busy_count = 0;

   logic [WIDTH-1:0] exp_q [$];
   logic             model_run;
   logic [WIDTH-1:0] model_t0;
   logic             model_ovf;

   cycle_span_capture #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_in   (cnt_in),
      .start    (start),
      .stop     (stop),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .busy     (busy),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Counts a comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                              input logic [WIDTH-1:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // One clock cycle with the current inputs; model updated alongside.
   task automatic applyStimulus();
      logic [WIDTH-1:0] head;
      logic             drop;
      checkOutput("m_valid", WIDTH'(m_valid), WIDTH'(exp_q.size() != 0));
      if (m_ready && exp_q.size() != 0) begin
         head = exp_q.pop_front();
         checkOutput("m_data", m_data, head);
      end
      drop = 1'b0;
      if (model_run && stop) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(cnt_in - model_t0);
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) begin
         model_ovf = 1'b1;
      end else if (clr_ovf) begin
         model_ovf = 1'b0;
      end
      if (!model_run) begin
         if (start) begin
            model_run = 1'b1;
            model_t0  = cnt_in;
         end
      end else if (stop) begin
         if (start) begin
            model_t0 = cnt_in;
         end else begin
            model_run = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (busy) begin
         busy_count++;
      end
      checkOutput("busy", WIDTH'(busy), WIDTH'(model_run));
      checkOutput("level", WIDTH'(level), WIDTH'(exp_q.size()));
      checkOutput("overflow", WIDTH'(overflow), WIDTH'(model_ovf));
      cnt_in  = cnt_in + 1;
      start   = 1'b0;
      stop    = 1'b0;
      clr_ovf = 1'b0;
   endtask

   // Start at start_cnt, stop len cycles later.
   task automatic runSpan(input logic [WIDTH-1:0] start_cnt, input int len,
                          input logic clr_on_stop);
      cnt_in = start_cnt;
      start  = 1'b1;
      applyStimulus();
      repeat (len - 1) applyStimulus();
      stop    = 1'b1;
      clr_ovf = clr_on_stop;
      applyStimulus();
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge.
   task automatic doReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_m_valid", WIDTH'(m_valid), WIDTH'(0));
      checkOutput("rst_m_data", m_data, WIDTH'(0));
      checkOutput("rst_busy", WIDTH'(busy), WIDTH'(0));
      checkOutput("rst_level", WIDTH'(level), WIDTH'(0));
      checkOutput("rst_overflow", WIDTH'(overflow), WIDTH'(0));
      exp_q.delete();
      model_run = 1'b0;
      model_t0  = '0;
      model_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Hard stop if the run ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios; all expected data comes from the scoreboard model.
   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      m_ready   = 1'b0;
      clr_ovf   = 1'b0;
      cnt_in    = '0;
      model_run = 1'b0;
      model_t0  = '0;
      model_ovf = 1'b0;
      #2;
      doReset();

      // Basic span of 42 cycles.
      m_ready    = 1'b1;
      busy_count = 0;
      runSpan(32'd100, 42, 1'b0);
      repeat (3) applyStimulus();
      checkOutput("busy_span", WIDTH'(busy_count), WIDTH'(42));

      // Span across counter wrap.
      runSpan(32'hFFFF_FFF0, 32, 1'b0);
      repeat (3) applyStimulus();

      // Lap with a stray start in between, then a stray stop in IDLE.
      cnt_in = 32'd10;
      start  = 1'b1;
      applyStimulus();
      repeat (9) applyStimulus();
      start = 1'b1;
      applyStimulus();
      repeat (9) applyStimulus();
      start = 1'b1;
      stop  = 1'b1;
      applyStimulus();
      repeat (24) applyStimulus();
      stop = 1'b1;
      applyStimulus();
      repeat (3) applyStimulus();
      stop = 1'b1;
      applyStimulus();
      repeat (2) applyStimulus();

      // Fill past capacity; the ninth stop also carries clr_ovf.
      m_ready = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         runSpan(cnt_in, k, k == 9);
      end
      checkOutput("full_level", WIDTH'(level), WIDTH'(DEPTH));
      checkOutput("ovf_set", WIDTH'(overflow), WIDTH'(1));
      clr_ovf = 1'b1;
      applyStimulus();
      checkOutput("ovf_clr", WIDTH'(overflow), WIDTH'(0));

      // Push into a full FIFO while the head is taken.
      start = 1'b1;
      applyStimulus();
      repeat (2) applyStimulus();
      stop    = 1'b1;
      m_ready = 1'b1;
      applyStimulus();
      m_ready = 1'b0;
      checkOutput("full_pop_level", WIDTH'(level), WIDTH'(DEPTH));
      checkOutput("full_pop_ovf", WIDTH'(overflow), WIDTH'(0));
      m_ready = 1'b1;
      repeat (10) applyStimulus();
      checkOutput("drained", WIDTH'(level), WIDTH'(0));

      // Reset while running with three queued entries.
      m_ready = 1'b0;
      runSpan(cnt_in, 1, 1'b0);
      runSpan(cnt_in, 2, 1'b0);
      runSpan(cnt_in, 3, 1'b0);
      start = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("pre_rst_busy", WIDTH'(busy), WIDTH'(1));
      checkOutput("pre_rst_level", WIDTH'(level), WIDTH'(3));
      doReset();
      m_ready = 1'b1;
      runSpan(32'd500, 7, 1'b0);
      repeat (3) applyStimulus();
      checkOutput("post_rst_level", WIDTH'(level), WIDTH'(0));
      checkOutput("sb_empty", WIDTH'(exp_q.size()), WIDTH'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cycle_span_capture.md
Name: cycle_span_capture

Overview:
- Consumer of the free-running cycle counter; converts start/stop event pulses into elapsed-cycle measurements.
- Captures counter value at start; on stop, computes elapsed = cnt_in - t0 (modular) and pushes it into a small FIFO.
- Host/readout logic drains the FIFO over a valid/ready interface.
- Sits beside the counter in the performance-measurement path of the accelerator.

Parameters:
- WIDTH, 32, width of counter input and measurement output.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AW, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cnt_in  in  WIDTH  free-running cycle count, sampled every clk
- start  in  1  single-cycle start event
- stop  in  1  single-cycle stop event
- m_valid  out  1  FIFO head holds a measurement
- m_ready  in  1  consumer accepts head this cycle
- m_data  out  WIDTH  elapsed cycles at FIFO head
- busy  out  1  measurement in progress (state RUN)
- level  out  AW+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a measurement was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset is rst, asynchronous, active-high. Clock is clk. All flops are rising-edge clk.
- Reset values: state=IDLE, t0=0, FIFO pointers=0, level=0, m_valid=0, m_data=0, busy=0, overflow=0.
- FSM IDLE:
  - start=1 -> t0<=cnt_in, go RUN.
  - stop alone is ignored.
  - start and stop together -> start wins; stop is ignored.
- FSM RUN:
  - stop=1, start=0 -> push (cnt_in - t0) mod 2^WIDTH, go IDLE.
  - start and stop together -> "lap": push (cnt_in - t0), then t0<=cnt_in, stay RUN.
  - start alone is ignored; t0 is not updated.
- busy = (state==RUN), registered.
- Arithmetic: unsigned WIDTH-bit subtraction, no saturation. Counter wrap is therefore correct for spans < 2^WIDTH. Example: t0=0xFFFFFFFE, cnt_in=0x00000003 -> 5.
- Push condition: level<DEPTH, or a pop occurs in the same cycle.
- Dropped push: when full with no pop, the measurement is dropped and overflow<=1. The FSM still transitions normally.
- Pop: occurs when m_valid && m_ready.
- Simultaneous push and pop:
  - Not empty: level unchanged, both succeed.
  - Empty: no pop occurs (m_valid=0); the push is stored.
- Latency: stop at edge N with the FIFO empty -> m_valid=1 and m_data valid after edge N+1. No combinational path from stop or cnt_in to m_data.
- Ordering and stability:
  - m_data and m_valid are driven from registered head storage.
  - m_data is stable while m_valid && !m_ready.
  - Order is strictly FIFO.
- level is updated in the same edge as the push/pop; it reflects the post-edge state.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - clr_ovf and a dropped push in the same cycle -> overflow=1 (set wins).
- Reset mid-RUN: the measurement is abandoned, FIFO contents are discarded, and no output is produced for the abandoned span.
- Pointer wrap: AW-bit read/write pointers wrap modulo DEPTH. Full/empty are derived from the level counter.

Decomposition:
- Shared package cycle_span_pkg holds:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - default WIDTH/DEPTH constants
  - a function returning modular span(cnt, t0)
- One natural sub-module: span_fifo, a synchronous single-clock FIFO with push/pop, level, registered head, DEPTH/WIDTH parameters.
- The FSM, t0 register, subtractor and overflow flag live in the top level.

Test Plan:
- Basic span: start at cnt_in=100, stop at cnt_in=142, m_ready=1 -> m_valid one cycle after stop, m_data=42, busy high for exactly 42 cycles, level returns to 0.
- Wrap: start at cnt_in=0xFFFFFFF0, stop at cnt_in=0x00000010 -> m_data=0x20.
- Lap and ignored events:
  - start at cnt_in=10, start+stop at 30, stop at 55 -> FIFO gets 20 then 25, in order.
  - A stray start during RUN does not move t0.
  - A stray stop in IDLE pushes nothing.
- Full/overflow with m_ready=0: nine start/stop pairs of spans 1..9:
  - level=8 and overflow=1.
  - Draining yields 1..8; span 9 is lost.
  - clr_ovf then clears overflow.
- Full with concurrent pop: at level=8, a stop on the same cycle as m_ready=1 -> level stays 8, overflow stays 0, the new span is last out.
- Reset mid-operation: rst asserted while busy=1 with level=3 -> all outputs immediately 0; a subsequent start at 500 / stop at 507 yields m_data=7 as the only entry.
